// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-ported data memory (port 0 = CPU, port 1 = loader).
// Grants alternate on contention with a bounded hold length; read data is captured one cycle after the access.
module dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_HOLD = 4      // legal range 1..15
) (
    input  logic          clk_i,
    input  logic          rst_i,

    input  logic          req0_i,
    input  logic          we0_i,
    input  logic [AW-1:0] addr0_i,
    input  logic [DW-1:0] wdata0_i,
    output logic          gnt0_o,
    output logic [DW-1:0] rdata0_o,
    output logic          rvalid0_o,

    input  logic          req1_i,
    input  logic          we1_i,
    input  logic [AW-1:0] addr1_i,
    input  logic [DW-1:0] wdata1_i,
    output logic          gnt1_o,
    output logic [DW-1:0] rdata1_o,
    output logic          rvalid1_o,

    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    output logic          mem_read_o,
    output logic          mem_write_o,
    input  logic [DW-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic       last_owner;
    logic       last_owner_nxt;

    logic       acc0;
    logic       acc1;
    logic       rd0;
    logic       rd1;

    // The owner has used up its hold budget with this access.
    function automatic logic hold_expired(input logic [3:0] c);
        return c == HOLD_LAST;
    endfunction

    assign acc0 = gnt0_o & req0_i;
    assign acc1 = gnt1_o & req1_i;
    assign rd0  = acc0 & ~we0_i;
    assign rd1  = acc1 & ~we1_i;

    assign mem_read_o  = rd0 | rd1;
    assign mem_write_o = (acc0 & we0_i) | (acc1 & we1_i);
    assign mem_addr_o  = acc0 ? addr0_i  : (acc1 ? addr1_i  : '0);
    assign mem_wdata_o = acc0 ? wdata0_i : (acc1 ? wdata1_i : '0);

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        last_owner_nxt = last_owner;
        case (state)
            IDLE: begin
                cnt_nxt = 4'd0;
                // On contention the port that was not served last wins.
                if (req0_i && (!req1_i || last_owner)) begin
                    state_nxt = OWN0;
                end else if (req1_i) begin
                    state_nxt = OWN1;
                end
            end
            OWN0: begin
                if (req0_i) begin
                    last_owner_nxt = 1'b0;
                    if (hold_expired(cnt)) begin
                        cnt_nxt = 4'd0;
                        if (req1_i) begin
                            state_nxt = OWN1;
                        end
                    end else begin
                        cnt_nxt = cnt + 4'd1;
                    end
                end else begin
                    cnt_nxt   = 4'd0;
                    state_nxt = req1_i ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                if (req1_i) begin
                    last_owner_nxt = 1'b1;
                    if (hold_expired(cnt)) begin
                        cnt_nxt = 4'd0;
                        if (req0_i) begin
                            state_nxt = OWN0;
                        end
                    end else begin
                        cnt_nxt = cnt + 4'd1;
                    end
                end else begin
                    cnt_nxt   = 4'd0;
                    state_nxt = req0_i ? OWN0 : IDLE;
                end
            end
            default: begin
                cnt_nxt   = 4'd0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Grants are registered copies of the next state so they change only on the clock edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            last_owner <= 1'b1;
            gnt0_o     <= 1'b0;
            gnt1_o     <= 1'b0;
            rvalid0_o  <= 1'b0;
            rvalid1_o  <= 1'b0;
            rdata0_o   <= '0;
            rdata1_o   <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            last_owner <= last_owner_nxt;
            gnt0_o     <= (state_nxt == OWN0);
            gnt1_o     <= (state_nxt == OWN1);
            rvalid0_o  <= rd0;
            rvalid1_o  <= rd1;
            if (rd0) begin
                rdata0_o <= mem_rdata_i;
            end
            if (rd1) begin
                rdata1_o <= mem_rdata_i;
            end
        end
    end

endmodule
